// File: rtl/alu4_arb.sv
// alu4_arb: two-requester arbiter/sequencer driving one shared alu4 and returning tagged results
// Ports: clk/rst (async, active-high); reqN_valid/ready/sel/a/b are op requests from requester N;
//        alu_en/sel/a/b drive the shared ALU and alu_c is its combinational result;
//        rsp_valid/ready/id/c form the tagged response channel; busy is high while an op is in flight.
// Optional: define ALU4_ARB_STATS_EN to add stat0/stat1, saturating 8-bit per-requester grant counters.
module alu4_arb #(
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [2:0] req0_sel,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [2:0] req1_sel,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       alu_en,
    output logic [2:0] alu_sel,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_c,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_c,
    output logic       busy
`ifdef ALU4_ARB_STATS_EN
    ,
    output logic [7:0] stat0,
    output logic [7:0] stat1
`endif
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state, state_nx;
    logic last_grant, pick1, accept, op_id;
    // alu_sel/alu_a/alu_b are the op registers themselves, so they hold outside EXEC
    always_comb begin
        pick1      = req1_valid && (!req0_valid || (!PRIO_FIXED && !last_grant));
        req0_ready = (state == IDLE) && req0_valid && !pick1;
        req1_ready = (state == IDLE) && pick1;
        accept     = req0_ready || req1_ready;
        state_nx   = state == IDLE ? (accept ? EXEC : IDLE) :
                     state == EXEC ? RESP : (rsp_ready ? IDLE : RESP);
        alu_en     = state == EXEC;
        rsp_valid  = state == RESP;
        busy       = state != IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_id      <= 1'b0;
            alu_sel    <= 3'd0;
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            rsp_id     <= 1'b0;
            rsp_c      <= 4'd0;
        end else begin
            state <= state_nx;
            if (accept) begin
                last_grant <= pick1;
                op_id      <= pick1;
                alu_sel    <= pick1 ? req1_sel : req0_sel;
                alu_a      <= pick1 ? req1_a : req0_a;
                alu_b      <= pick1 ? req1_b : req0_b;
            end
            if (state == EXEC) begin
                rsp_c  <= alu_c;
                rsp_id <= op_id;
            end
        end
    end
`ifdef ALU4_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat0 <= 8'd0;
            stat1 <= 8'd0;
        end else begin
            if (req0_ready && stat0 != 8'hFF) stat0 <= stat0 + 8'd1;
            if (req1_ready && stat1 != 8'hFF) stat1 <= stat1 + 8'd1;
        end
    end
`endif
endmodule
